// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg: shared FSM state encodings and requester count for rr_arbiter4
package rr_arbiter4_pkg;
  localparam int N_REQ = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arbiter4_grant_decode.sv
// grant_decode: combinational 2-to-4 one-hot decoder
//   in  : binary requester index
//   out : one-hot vector, out[k] = (in == k)
module grant_decode
  import rr_arbiter4_pkg::*;
(
  input  logic [1:0]       in,
  output logic [N_REQ-1:0] out
);
  assign out = N_REQ'(1) << in;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with hold limit and turnaround cycle
//   clk         : system clock, rising edge
//   rst_n       : synchronous active-low reset
//   en          : arbitration enable (gates new grants only)
//   req         : level-sensitive request vector
//   grant       : registered one-hot grant, zero when no owner
//   grant_valid : high while any grant bit is set
//   grant_idx   : index of current or last owner
//   timeout     : one-cycle pulse on a forced release at MAX_HOLD
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [1:0]       grant_idx,
  output logic             timeout
);
  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, dec_out;
  logic [1:0]       idx_q, idx_d, ptr_q, ptr_d, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    win = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (en && |req) begin
        state_d = GRANT;
        idx_d   = win;
        ptr_d   = win + 2'd1;
        cnt_d   = CNT_W'(1);
      end
      GRANT: begin
        if (!req[idx_q]) state_d = TURN;
        else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          state_d   = TURN;
          timeout_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == GRANT) ? dec_out : '0;
  end

  grant_decode u_dec (
    .in  (idx_d),
    .out (dec_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;
  assign timeout     = timeout_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed self-checking bench for rr_arbiter4
module tb_rr_arbiter4;
  logic       clk = 0, rst_n = 0, en = 0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       grant_valid, timeout;
  logic [1:0] grant_idx;
  int errors = 0, checks = 0;

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    en = 1; req = 4'b1111; rst_n = 0;
    tick(2);
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state grant=%b valid=%b idx=%0d timeout=%b, want 0000/0/0/0", grant, grant_valid, grant_idx, timeout);
    end
    rst_n = 1;
    tick(1);
    checks++;
    if (grant !== 4'b0001 || grant_valid !== 1'b1 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant grant=%b valid=%b idx=%0d, want 0001/1/0", grant, grant_valid, grant_idx);
    end
  endtask

  task automatic test_rotation;
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (grant !== 4'(1 << o) || grant_valid !== 1'b1 || timeout !== 1'b0 || grant_idx !== 2'(o)) begin
          errors++;
          $display("FAIL rotation_hold owner=%0d cyc=%0d grant=%b valid=%b timeout=%b idx=%0d, want %b/1/0/%0d",
                   o, c, grant, grant_valid, timeout, grant_idx, 4'(1 << o), o);
        end
        tick(1);
      end
      checks++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0 || timeout !== 1'b1 || grant_idx !== 2'(o)) begin
        errors++;
        $display("FAIL rotation_timeout owner=%0d grant=%b valid=%b timeout=%b idx=%0d, want 0000/0/1/%0d",
                 o, grant, grant_valid, timeout, grant_idx, o);
      end
      tick(1);
      checks++;
      if (grant !== 4'b0000 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL rotation_gap owner=%0d grant=%b timeout=%b, want 0000/0", o, grant, timeout);
      end
      tick(1);
    end
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL rotation_wrap grant=%b, want 0001", grant);
    end
    req = 4'b0000;
    tick(2);
  endtask

  task automatic test_early_release;
    req = 4'b0100;
    tick(1);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
        errors++;
        $display("FAIL early_hold cyc=%0d grant=%b idx=%0d, want 0100/2", c, grant, grant_idx);
      end
      if (c < 2) tick(1);
    end
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick(1);
      checks++;
      if (grant !== 4'b0000 || timeout !== 1'b0 || grant_idx !== 2'd2) begin
        errors++;
        $display("FAIL early_release cyc=%0d grant=%b timeout=%b idx=%0d, want 0000/0/2", c, grant, timeout, grant_idx);
      end
    end
    req = 4'b1001;
    tick(1);
    checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
      errors++;
      $display("FAIL early_next_ptr grant=%b idx=%0d, want 1000/3", grant, grant_idx);
    end
    req = 4'b0000;
    tick(2);
  endtask

  task automatic test_skip_idle;
    req = 4'b0001;
    tick(1);
    req = 4'b0000;
    tick(2);
    req = 4'b0001;
    tick(1);
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL skip_wrap grant=%b idx=%0d, want 0001/0", grant, grant_idx);
    end
    req = 4'b0000;
    tick(2);
  endtask

  task automatic test_enable;
    en = 0; req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      checks++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL enable_block cyc=%0d grant=%b valid=%b, want 0000/0", c, grant, grant_valid);
      end
    end
    en = 1;
    tick(1);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL enable_grant grant=%b, want 0010", grant);
    end
    en = 0;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      checks++;
      if (grant !== 4'b0010 || grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL enable_drop_hold cyc=%0d grant=%b valid=%b, want 0010/1", c, grant, grant_valid);
      end
    end
    req = 4'b0000;
    tick(2);
    req = 4'b0001;
    tick(2);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL enable_park grant=%b, want 0000", grant);
    end
    req = 4'b0000; en = 1;
    tick(1);
  endtask

  task automatic test_reset_mid_grant;
    req = 4'b0100;
    tick(5);
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_owner grant=%b, want 0100", grant);
    end
    rst_n = 0;
    tick(1);
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop grant=%b valid=%b idx=%0d timeout=%b, want 0000/0/0/0", grant, grant_valid, grant_idx, timeout);
    end
    rst_n = 1; req = 4'b1111;
    tick(1);
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL midrst_restart grant=%b idx=%0d, want 0001/0", grant, grant_idx);
    end
  endtask

  initial begin
    tick(1);
    test_reset;
    test_rotation;
    test_early_release;
    test_skip_idle;
    test_enable;
    test_reset_mid_grant;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
